// File: rtl/output_layer_pkg.sv
// Shared types, default widths and the Q8.8 saturation helper for the output layer.
package output_layer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_DEF   = 8;
  localparam int ACC_W_DEF  = 40;

  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = 16'sh8000;

  localparam logic signed [ACC_W_DEF-1:0] SAT_MAX_ACC = 40'sh00_0000_7FFF;
  localparam logic signed [ACC_W_DEF-1:0] SAT_MIN_ACC = 40'shFF_FFFF_8000;

  function automatic logic signed [DATA_W_DEF-1:0] saturate(input logic signed [ACC_W_DEF-1:0] x);
    logic signed [DATA_W_DEF-1:0] r;
    if (x > SAT_MAX_ACC) begin
      r = SAT_MAX;
    end else if (x < SAT_MIN_ACC) begin
      r = SAT_MIN;
    end else begin
      r = x[DATA_W_DEF-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/output_layer_mac.sv
// Registered signed multiply-accumulate with clear/enable; the read port rescales
// the accumulator to Q8.8, adds the bias and saturates.
module output_layer_mac
  import output_layer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] bias_i,
  output logic [DATA_W-1:0] result_o
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    shr_s;
  logic signed [ACC_W-1:0]    sum_s;

  assign prod_s = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
  // Shift kept in its own signed net so the >>> stays arithmetic.
  assign shr_s  = acc_q >>> FRAC;
  assign sum_s  = shr_s + $signed({{(ACC_W-DATA_W){bias_i[DATA_W-1]}}, bias_i});
  assign result_o = saturate(sum_s);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + $signed({{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s});
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/output_layer_seq.sv
// Sequencer for the fully connected output layer: one shared MAC walks every node.
// Optional running argmax output enabled by defining OUTPUT_LAYER_ARGMAX_EN.
module output_layer_seq
  import output_layer_pkg::*;
#(
  parameter int N_IN   = 10,
  parameter int N_OUT  = 10,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  localparam int IW    = $clog2(N_IN),
  localparam int WAW   = $clog2(N_IN*N_OUT),
  localparam int NW    = $clog2(N_OUT),
  localparam int KW    = $clog2(N_IN+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [IW-1:0]     hidden_idx,
  input  logic [DATA_W-1:0] hidden_data,
  output logic [WAW-1:0]    w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [NW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              out_wr,
  output logic [NW-1:0]     out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
`ifdef OUTPUT_LAYER_ARGMAX_EN
  ,
  output logic [NW-1:0]     pred_idx,
  output logic              pred_valid
`endif
);

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [NW-1:0]     node_q, node_d;
  logic [DATA_W-1:0] h_q;
  logic [DATA_W-1:0] result_s;
  logic [IW-1:0]     hidden_idx_q;
  logic [WAW-1:0]    w_addr_q;
  logic [NW-1:0]     b_addr_q;
  logic [NW-1:0]     out_idx_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_wr_q, busy_q, done_q;
  logic              mac_en_s, acc_clr_s, issue_s;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    node_d  = node_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          k_d     = '0;
          node_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        if (k_q == KW'(N_IN)) begin
          state_d = BIAS;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      BIAS: begin
        if (node_q == NW'(N_OUT-1)) begin
          state_d = DONE;
          node_d  = '0;
        end else begin
          state_d = MAC;
          node_d  = node_q + NW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase k=0 only fetches operands; products arrive from k=1 onwards.
  assign mac_en_s  = (state_q == MAC) && (k_q != '0);
  assign acc_clr_s = (state_q != MAC);
  assign issue_s   = (state_d == MAC) && (k_d < KW'(N_IN));

  output_layer_mac #(
    .DATA_W(DATA_W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (acc_clr_s),
    .en_i    (mac_en_s),
    .a_i     (h_q),
    .b_i     (w_data),
    .bias_i  (b_data),
    .result_o(result_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      node_q       <= '0;
      h_q          <= '0;
      hidden_idx_q <= '0;
      w_addr_q     <= '0;
      b_addr_q     <= '0;
      out_wr_q     <= 1'b0;
      out_idx_q    <= '0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      node_q  <= node_d;
      if (issue_s) begin
        w_addr_q     <= WAW'(node_d) * WAW'(N_IN) + WAW'(k_d);
        hidden_idx_q <= IW'(k_d);
      end
      // Bias address is issued early and held so b_data is stable in BIAS.
      if ((state_d == MAC) && (k_d == KW'(N_IN-1))) begin
        b_addr_q <= node_d;
      end
      if ((state_q == MAC) && (k_q < KW'(N_IN))) begin
        h_q <= hidden_data;
      end
      out_wr_q <= (state_q == BIAS);
      if (state_q == BIAS) begin
        out_idx_q  <= node_q;
        out_data_q <= result_s;
      end
      busy_q <= (state_d == MAC) || (state_d == BIAS);
      done_q <= (state_d == DONE);
    end
  end

  assign hidden_idx = hidden_idx_q;
  assign w_addr     = w_addr_q;
  assign b_addr     = b_addr_q;
  assign out_wr     = out_wr_q;
  assign out_idx    = out_idx_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef OUTPUT_LAYER_ARGMAX_EN
  logic signed [DATA_W-1:0] max_q;
  logic [NW-1:0]            best_q, best_d, pred_idx_q;
  logic                     pred_valid_q, take_s;

  // Strict greater-than keeps the lower index on ties.
  assign take_s = (state_q == BIAS) && ((node_q == '0) || ($signed(result_s) > max_q));

  always_comb begin
    if (take_s) begin
      best_d = node_q;
    end else begin
      best_d = best_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q        <= '0;
      best_q       <= '0;
      pred_idx_q   <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      if (take_s) begin
        max_q  <= $signed(result_s);
        best_q <= node_q;
      end
      pred_valid_q <= (state_d == DONE);
      if (state_d == DONE) begin
        pred_idx_q <= best_d;
      end
    end
  end

  assign pred_idx   = pred_idx_q;
  assign pred_valid = pred_valid_q;
`endif

endmodule
